instr_decode_ctrl: RTL and testbench

//   Multi-cycle fetch/decode controller upstream of alucontrol and the ALU datapath.
//   - Fetches one 16-bit instruction per handshake and holds it in an instruction register (IR).
//   - Issues opcode/opext to alucontrol, plus register addresses, extended immediate and datapath strobes.
//   - Sequences FETCH -> DECODE -> EXECUTE -> WRITEBACK, so exactly one instruction is in flight.

---
 rtl/cr16_pkg.sv | 18 +
 rtl/imm_ext.sv | 8 +
 rtl/instr_decode_ctrl.sv | 64 ++++++
 tb/tb_instr_decode_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/cr16_pkg.sv
// cr16_pkg: shared opcode/opext encodings and controller state encoding
package cr16_pkg;
  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b1001;
  localparam logic [3:0] OP_AND   = 4'b0001;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_OR    = 4'b0010;
  localparam logic [3:0] EXT_ADD  = 4'b0101;
  localparam logic [3:0] EXT_SUB  = 4'b1001;
  localparam logic [3:0] EXT_AND  = 4'b0001;
  localparam logic [3:0] EXT_XOR  = 4'b0011;
  localparam logic [3:0] EXT_OR   = 4'b0010;
  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_WB} state_t;
  function automatic logic is_alu_fn(input logic [3:0] f);
    return f == OP_ADD || f == OP_SUB || f == OP_AND || f == OP_XOR || f == OP_OR;
  endfunction
endpackage

// File: rtl/imm_ext.sv
// imm_ext: 8-to-16 bit immediate extender, sign or zero
module imm_ext (
  input  logic [7:0]  imm8,
  input  logic        sign_ext,
  output logic [15:0] imm16
);
  assign imm16 = {{8{sign_ext & imm8[7]}}, imm8};
endmodule

// File: rtl/instr_decode_ctrl.sv
// instr_decode_ctrl: fetch/decode/execute/writeback controller, one instruction in flight
module instr_decode_ctrl
  import cr16_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] instr,
  output logic [3:0]        opcode,
  output logic [3:0]        opext,
  output logic [REG_AW-1:0] ra1,
  output logic [REG_AW-1:0] ra2,
  output logic [REG_AW-1:0] wa,
  output logic [DATA_W-1:0] imm,
  output logic              alusrcb,
  output logic              regwrite,
  output logic              pc_en,
  output logic              illegal,
  output logic [CNT_W-1:0]  retired
);
  state_t state, nxt;
  logic [DATA_W-1:0] ir;
  logic legal_q, itype, legal;
  assign opcode = ir[15:12];
  assign opext  = ir[7:4];
  assign ra1    = ir[11:8];
  assign ra2    = ir[3:0];
  assign wa     = ir[11:8];
  assign itype  = is_alu_fn(opcode);
  assign legal  = itype || (opcode == OP_RTYPE && is_alu_fn(opext));
  imm_ext u_imm_ext (
    .imm8     (ir[7:0]),
    .sign_ext (opcode == OP_ADD || opcode == OP_SUB),
    .imm16    (imm)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_FETCH;
      ir      <= '0;
      legal_q <= 1'b0;
      retired <= '0;
    end else begin
      state <= nxt;
      if (state == S_FETCH && mem_ack) ir <= instr;
      if (state == S_DECODE) legal_q <= legal;
      if (state == S_WB && legal_q) retired <= retired + CNT_W'(1);
    end
  end
  // mem_req is masked by reset so it reads 0 while reset is held
  always_comb begin
    nxt      = state == S_FETCH ? (mem_ack ? S_DECODE : S_FETCH) :
               state == S_DECODE ? S_EXEC : state == S_EXEC ? S_WB : S_FETCH;
    mem_req  = state == S_FETCH && !reset;
    alusrcb  = itype;
    pc_en    = state == S_WB;
    regwrite = state == S_WB && legal_q;
    illegal  = state == S_WB && !legal_q;
  end
endmodule

// File: tb/tb_instr_decode_ctrl.sv
// tb_instr_decode_ctrl: table-driven and randomized checks against a spec-level model
module tb_instr_decode_ctrl;
  localparam int CW = 8;
  logic clk = 0, reset = 1, mem_ack = 0;
  logic [15:0] instr = 0;
  logic mem_req, alusrcb, regwrite, pc_en, illegal;
  logic [3:0] opcode, opext, ra1, ra2, wa;
  logic [15:0] imm;
  logic [CW-1:0] retired;
  int errs = 0, checks = 0, model_ret = 0;
  logic [15:0] last_ir = 0;

  instr_decode_ctrl #(.DATA_W(16), .REG_AW(4), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_ack(mem_ack), .instr(instr),
    .opcode(opcode), .opext(opext), .ra1(ra1), .ra2(ra2), .wa(wa), .imm(imm),
    .alusrcb(alusrcb), .regwrite(regwrite), .pc_en(pc_en), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ins;
    int          wait_n;
    bit          stray;
    bit          exp_legal;
    bit          exp_b;
    logic [15:0] exp_imm;
  } vec_t;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Spec-level classification: ALU function set, sign-extend only add/sub immediates
  function automatic void ref_dec(input logic [15:0] i, output bit lg, output bit b, output logic [15:0] im);
    logic [3:0] op, ex;
    bit fn_op, fn_ex;
    op = i[15:12];
    ex = i[7:4];
    fn_op = op inside {4'h5, 4'h9, 4'h1, 4'h3, 4'h2};
    fn_ex = ex inside {4'h5, 4'h9, 4'h1, 4'h3, 4'h2};
    b  = fn_op;
    lg = fn_op || (op == 4'h0 && fn_ex);
    im = (op == 4'h5 || op == 4'h9) ? 16'($signed(i[7:0])) : {8'h00, i[7:0]};
  endfunction

  task automatic fields(input string n, input logic [15:0] ins, input logic [15:0] exp_imm, input bit exp_b);
    chk({n, "_ir"}, {opcode, ra1, opext, ra2}, ins);
    chk({n, "_wa"}, wa, ins[11:8]);
    chk({n, "_imm"}, imm, exp_imm);
    chk({n, "_alusrcb"}, alusrcb, exp_b);
  endtask

  task automatic run(input logic [15:0] ins, input int wait_n, input bit stray,
                     input bit exp_legal, input bit exp_b, input logic [15:0] exp_imm);
    chk("fetch_req", mem_req, 1);
    for (int k = 0; k < wait_n; k++) begin
      mem_ack = 0;
      instr = 16'($urandom);
      step;
      chk("wait_req", mem_req, 1);
      chk("ir_hold", {opcode, ra1, opext, ra2}, last_ir);
    end
    mem_ack = 1;
    instr = ins;
    step;
    mem_ack = 0;
    instr = 16'($urandom);
    chk("dec_req", mem_req, 0);
    chk("dec_strobes", {regwrite, pc_en, illegal}, 0);
    fields("dec", ins, exp_imm, exp_b);
    step;
    chk("exe_strobes", {mem_req, regwrite, pc_en, illegal}, 0);
    fields("exe", ins, exp_imm, exp_b);
    if (stray) begin
      mem_ack = 1;
      instr = ~ins;
    end
    step;
    mem_ack = 0;
    chk("wb_strobes", {mem_req, regwrite, pc_en, illegal}, {1'b0, exp_legal, 1'b1, !exp_legal});
    fields("wb", ins, exp_imm, exp_b);
    if (exp_legal) model_ret = (model_ret + 1) % (1 << CW);
    step;
    chk("post_strobes", {mem_req, regwrite, pc_en, illegal}, 4'b1000);
    chk("retired", retired, model_ret);
    last_ir = ins;
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{16'h53FF, 0, 0, 1, 1, 16'hFFFF});
    vecs.push_back('{16'h13F0, 0, 0, 1, 1, 16'h00F0});
    vecs.push_back('{16'h0251, 0, 0, 1, 0, 16'h0051});
    vecs.push_back('{16'hF000, 0, 0, 0, 0, 16'h0000});
    vecs.push_back('{16'h9280, 3, 1, 1, 1, 16'hFF80});
    vecs.push_back('{16'h3A7F, 1, 0, 1, 1, 16'h007F});
    vecs.push_back('{16'h0391, 0, 1, 1, 0, 16'h0091});
    vecs.push_back('{16'h0061, 2, 0, 0, 0, 16'h0061});
    vecs.push_back('{16'h2C85, 0, 0, 1, 1, 16'h0085});
    vecs.push_back('{16'h0C4A, 0, 0, 0, 0, 16'h004A});
    #1;
    chk("rst_outs", {mem_req, regwrite, pc_en, illegal, alusrcb}, 0);
    chk("rst_ir", {opcode, ra1, opext, ra2, wa}, 0);
    chk("rst_imm", imm, 0);
    chk("rst_retired", retired, 0);
    step;
    step;
    reset = 0;
    #1;
    chk("rel_req", mem_req, 1);
    foreach (vecs[i]) run(vecs[i].ins, vecs[i].wait_n, vecs[i].stray, vecs[i].exp_legal, vecs[i].exp_b, vecs[i].exp_imm);
    for (int n = 0; n < 150; n++) begin
      logic [15:0] ins, im;
      bit lg, b;
      logic [3:0] fn;
      fn = 4'({$urandom_range(0, 4)} == 0 ? 5 : {$urandom_range(0, 4)} == 1 ? 9 : {$urandom_range(1, 3)});
      ins = 16'($urandom);
      case ($urandom_range(0, 3))
        1: ins[15:12] = fn;
        2: begin ins[15:12] = 4'h0; ins[7:4] = fn; end
        3: ins[15:12] = 4'h0;
        default: ;
      endcase
      ref_dec(ins, lg, b, im);
      run(ins, $urandom_range(0, 3), 1'($urandom_range(0, 1)), lg, b, im);
    end
    mem_ack = 1;
    instr = 16'h53FF;
    step;
    mem_ack = 0;
    step;
    reset = 1;
    #1;
    chk("arst_strobes", {mem_req, regwrite, pc_en, illegal, alusrcb}, 0);
    chk("arst_ir", {opcode, ra1, opext, ra2}, 0);
    chk("arst_retired", retired, 0);
    model_ret = 0;
    last_ir = 0;
    step;
    reset = 0;
    #1;
    chk("arel_req", mem_req, 1);
    step;
    chk("arel_noact", {mem_req, regwrite, pc_en, illegal}, 4'b1000);
    chk("arel_retired", retired, 0);
    while (model_ret != (1 << CW) - 1) run(16'h5101, 0, 0, 1, 1, 16'h0001);
    chk("pre_wrap", retired, (1 << CW) - 1);
    run(16'h0425, 0, 0, 1, 0, 16'h0025);
    chk("wrap", retired, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
